// File: rtl/inport_vcbuf.sv
// Input-port virtual-channel buffer: per-VC flit FIFOs, packet-level round-robin
// VC selection, pre-routed port/multicast status for the crossbar, and credit return.
module inport_vcbuf #(
    parameter int VCH     = 2,
    parameter int DEPTH   = 4,
    parameter int DATAW   = 31,
    parameter int PORTW   = 2,
    parameter int DSTATUS = 1,
    parameter int VCHW    = 0,
    parameter int PORT    = 4
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [DATAW:0]     idata,
    input  logic               ivalid,
    input  logic [VCHW:0]      ivch,
    output logic [VCH-1:0]     ocredit,
    output logic [DATAW:0]     odata,
    output logic               ovalid,
    output logic [VCHW:0]      ovch,
    output logic [PORTW:0]     port,
    output logic               req,
    output logic [DSTATUS:0]   multab,
    input  logic [PORT:0]      grt,
    output logic               err
);

    localparam int VW = VCHW + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [DATAW:0]   mem_q   [VCH][DEPTH];
    logic [DATAW:0]   mem_d   [VCH][DEPTH];
    logic [PW-1:0]    wptr_q  [VCH];
    logic [PW-1:0]    wptr_d  [VCH];
    logic [PW-1:0]    rptr_q  [VCH];
    logic [PW-1:0]    rptr_d  [VCH];
    logic [CW-1:0]    cnt_q   [VCH];
    logic [CW-1:0]    cnt_d   [VCH];
    logic             locked_q, locked_d;
    logic [VW-1:0]    cur_vc_q, cur_vc_d;
    logic [VW-1:0]    rr_q, rr_d;
    logic [PORTW:0]   port_q, port_d;
    logic [DSTATUS:0] multab_q, multab_d;
    logic             err_q, err_d;
    logic [VCH-1:0]   ocredit_q, ocredit_d;

    logic             req_s;
    logic             ovalid_s;
    logic [DATAW:0]   head_cur_s;
    logic [DATAW:0]   head_pick_s;
    logic             found_s;
    logic [VW-1:0]    pick_s;
    logic             wr_s;
    logic             deq_s;
    logic [VW-1:0]    deq_vc_s;
    int               scan_idx;

    // Crossbar-facing view of the locked VC; req never depends on grt or ivalid.
    always_comb begin
        head_cur_s = mem_q[cur_vc_q][rptr_q[cur_vc_q]];
        req_s      = locked_q && (cnt_q[cur_vc_q] != '0);
        ovalid_s   = req_s && (|grt);
    end

    assign req     = req_s;
    assign ovalid  = ovalid_s;
    assign odata   = locked_q ? head_cur_s : '0;
    assign ovch    = cur_vc_q;
    assign port    = port_q;
    assign multab  = multab_q;
    assign err     = err_q;
    assign ocredit = ocredit_q;

    // Next-state: round-robin scan, lock/unlock, FIFO enqueue/dequeue, credits, error.
    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        locked_d  = locked_q;
        cur_vc_d  = cur_vc_q;
        rr_d      = rr_q;
        port_d    = port_q;
        multab_d  = multab_q;
        err_d     = err_q;
        ocredit_d = '0;
        found_s   = 1'b0;
        pick_s    = '0;
        deq_s     = 1'b0;
        deq_vc_s  = '0;
        scan_idx  = 0;

        // First non-empty VC at or after rr, using counts before this edge's writes.
        for (int i = 0; i < VCH; i++) begin
            scan_idx = (int'(rr_q) + i) % VCH;
            if (!found_s && (cnt_q[scan_idx] != '0)) begin
                found_s = 1'b1;
                pick_s  = VW'(scan_idx);
            end else begin
                found_s = found_s;
            end
        end
        head_pick_s = mem_q[pick_s][rptr_q[pick_s]];

        if (locked_q) begin
            if (ovalid_s) begin
                deq_s    = 1'b1;
                deq_vc_s = cur_vc_q;
                if (head_cur_s[DATAW]) begin
                    locked_d = 1'b0;
                    rr_d     = VW'((int'(cur_vc_q) + 1) % VCH);
                end else begin
                    locked_d = 1'b1;
                end
            end else begin
                locked_d = 1'b1;
            end
        end else if (found_s) begin
            if (head_pick_s[DATAW-1]) begin
                locked_d = 1'b1;
                cur_vc_d = pick_s;
                port_d   = head_pick_s[PORTW:0];
                multab_d = head_pick_s[PORTW+DSTATUS+1:PORTW+1];
            end else begin
                // Stray body/tail with no open packet: discard and refund the slot.
                deq_s    = 1'b1;
                deq_vc_s = pick_s;
                err_d    = 1'b1;
            end
        end else begin
            locked_d = 1'b0;
        end

        wr_s = ivalid && (int'(ivch) < VCH) && (cnt_q[ivch] != CW'(DEPTH));
        if (ivalid && !wr_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end

        if (wr_s) begin
            mem_d[ivch][wptr_q[ivch]] = idata;
            wptr_d[ivch]              = wptr_q[ivch] + PW'(1);
        end else begin
            wptr_d = wptr_d;
        end

        if (deq_s) begin
            rptr_d[deq_vc_s]    = rptr_q[deq_vc_s] + PW'(1);
            ocredit_d[deq_vc_s] = 1'b1;
        end else begin
            rptr_d = rptr_d;
        end

        for (int v = 0; v < VCH; v++) begin
            cnt_d[v] = cnt_q[v]
                     + CW'(wr_s && (ivch == VW'(v)))
                     - CW'(deq_s && (deq_vc_s == VW'(v)));
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_q     <= '{default: '0};
            wptr_q    <= '{default: '0};
            rptr_q    <= '{default: '0};
            cnt_q     <= '{default: '0};
            locked_q  <= 1'b0;
            cur_vc_q  <= '0;
            rr_q      <= '0;
            port_q    <= '0;
            multab_q  <= '0;
            err_q     <= 1'b0;
            ocredit_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            locked_q  <= locked_d;
            cur_vc_q  <= cur_vc_d;
            rr_q      <= rr_d;
            port_q    <= port_d;
            multab_q  <= multab_d;
            err_q     <= err_d;
            ocredit_q <= ocredit_d;
        end
    end

endmodule

// File: doc/inport_vcbuf.md
# inport_vcbuf

Input-port virtual-channel buffer for one router input, feeding one `idata_N`/`ivalid_N`/`ivch_N`/`port_N`/`req_N`/`multab_N` slot of the 5-port crossbar and consuming its `grt_N` vector. It stores link flits in per-VC FIFOs and picks one VC at a time with packet-level round-robin. It presents that VC's flits with the pre-routed output port and multicast/absorb status, and returns one credit per freed slot to the upstream router. The router instantiates it five times, once per input port.

## Interface
- `VCH`, default 2: number of virtual channels; must satisfy VCH ≤ 2^(`VCHW`+1).
- `DEPTH`, default 4: flits per VC FIFO; must be a power of two, ≥ 2.
- `clk` in 1: the block's single clock.
- `rst_` in 1: asynchronous, active-low reset.
- `idata` in [`DATAW`:0]: flit from the link.
  - Bits [`DATAW`:`DATAW`-1] are the flit type: 01 head, 00 body, 10 tail, 11 single (head+tail).
  - Head flit bits [`PORTW`:0] are the destination output port.
  - Head flit bits [`PORTW`+`DSTATUS`+1:`PORTW`+1] are the multicast/absorb status.
- `ivalid` in 1: flit present this cycle.
- `ivch` in [`VCHW`:0]: VC of the incoming flit.
- `ocredit` out [VCH-1:0]: registered one-cycle pulse per VC, one slot freed.
- `odata` out [`DATAW`:0]: head-of-FIFO flit of the locked VC.
- `ovalid` out 1: flit is transferred this cycle.
- `ovch` out [`VCHW`:0]: locked VC index.
- `port` out [`PORTW`:0]: latched destination port of the locked packet.
- `req` out 1: crossbar request.
- `multab` out [`DSTATUS`:0]: latched multicast/absorb status of the locked packet.
- `grt` in [`PORT`:0]: grant vector from the crossbar. One-hot, or multi-hot for multicast.
- `err` out 1: sticky protocol-error flag.

## Operation
- **Enqueue.** When `ivalid` is high and FIFO[`ivch`] is not full, the flit is written at the clock edge.
  - Fullness uses the pre-dequeue count. A write to a full FIFO is dropped and sets `err`, even if the same VC dequeues in that cycle.
  - `ivch` ≥ VCH: the flit is dropped and `err` is set.
- **Lock register** holds {locked, cur_vc, port, multab}.
- **Unlocked state.** At each edge, the round-robin pointer scans VCs rr, rr+1, … and picks the first VC whose FIFO is non-empty.
  - Head-of-FIFO type 01 or 11: set locked, cur_vc = VC, and latch port and multab from the flit. The flit is not dequeued.
  - Head-of-FIFO type 00 or 10: dequeue and discard it, pulse that VC's credit, set `err`. The block stays unlocked and rr does not advance.
- **Locked state.**
  - `req` = locked & FIFO[cur_vc] non-empty.
  - `ovalid` = `req` & |`grt`.
  - `odata` = head of FIFO[cur_vc]; `ovch` = cur_vc.
  - On `ovalid`, dequeue the flit and pulse `ocredit[cur_vc]` on the next cycle.
  - If the dequeued flit is type 10 or 11, clear the lock and set rr = cur_vc+1 mod VCH.
- **Mid-packet starvation.** If FIFO[cur_vc] empties mid-packet, `req` drops while the lock is held. Other VCs are not served until the tail has been sent.
- **Error flag.** `err` is cleared only by reset.

## Timing
- **Reset values.** Asynchronous reset immediately forces:
  - all FIFOs empty, rr = 0, lock cleared;
  - `ocredit`, `req`, `ovalid`, `port`, `multab`, `ovch`, `err` all 0;
  - `odata` reads 0.
  - Reset mid-packet discards all buffered flits, and no credits are returned for them.
- **Head latency.** A head flit with `ivalid` in cycle 0 on an empty, unlocked block gives `req` = 1 in cycle 2.
- **No combinational input paths to req/port/multab.** `req`, `port` and `multab` depend only on registers; `grt` and `ivalid` have no combinational path to them.
- **Same-cycle transfer.** `ovalid`, `odata` and `ovch` are valid in the same cycle as `grt`.
- **Streaming.** A granted packet streams one flit per cycle while `grt` is held and the FIFO is non-empty.
- **Credit timing.** `ocredit` rises the cycle after the dequeue edge and lasts one cycle.
- **Bubble after tail.** After a tail is dequeued there is one unlocked cycle. The earliest next `req` is 2 cycles after the tail's transfer cycle.
- **Simultaneous enqueue and dequeue** on the same non-full VC are both performed; the count is unchanged.

## Test plan
- **Reset.** Assert `rst_` = 0 asynchronously mid-cycle with a packet locked.
  - All outputs are 0 at once.
  - After release, `req` stays 0 until new flits arrive.
- **Single-flit packet.** Cycle 0: flit type 11, port 3, VC0.
  - Cycle 2: `req` = 1, `port` = 3.
  - Drive `grt` = 5'b01000 in cycle 2: `ovalid` = 1, `ovch` = 0, `odata` = the flit.
  - Cycle 3: `ocredit` = 2'b01, `req` = 0.
- **3-flit packet.** Head/body/tail on VC1 in cycles 0–2, port 1, `grt` = 5'b00010 held.
  - Flits leave in cycles 2, 3, 4 in order.
  - `ocredit` = 2'b10 in cycles 3–5.
  - `req` = 0 in cycle 5.
- **Round-robin.** Single-flit packets are queued on both VC0 and VC1, with `grt` always granting.
  - VC0 is served first.
  - One bubble cycle follows, then VC1 is served.
  - A third packet on VC0 is served after VC1.
- **Overflow.** Five flits on VC0 (head + 4 body) with no grant.
  - The 5th flit is dropped and `err` = 1.
  - Later grants output only the first 4 flits.
  - `err` stays 1.
- **Stray body flit.** A body flit is written to VC1 while unlocked.
  - It is discarded 1 cycle later.
  - `ocredit` = 2'b10 the following cycle, `err` = 1, and `req` stays 0.
